// File: rtl/tespar_histogram.sv
// TESPAR symbol histogram. Accumulates 32 saturating bins over one frame of
// symbols, then streams the bins out in index order with a valid/ready
// handshake, clearing each bin as it is taken.
module tespar_histogram #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             flush,
  output logic [4:0]       out_index,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_sat
);

  typedef enum logic [0:0] {StAccum, StDump} state_e;

  localparam logic [15:0]      FrameLast = 16'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bins_q [32];
  logic [CNT_W-1:0] bins_d [32];
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             sat_q, sat_d;
  logic             accept;

  assign accept = (state_q == StAccum) && sym_valid;

  // Next-state: bin accumulation in ACCUM, bin drain in DUMP.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    sat_d       = sat_q;
    for (int i = 0; i < 32; i++) begin
      bins_d[i] = bins_q[i];
    end
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          // A full bin stays full; the symbol still counts toward the frame.
          if (bins_q[sym_in] == CntMax) begin
            sat_d = 1'b1;
          end else begin
            bins_d[sym_in] = bins_q[sym_in] + 1'b1;
          end
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if ((accept && (frame_cnt_d == FrameLast)) ||
            (flush && ((frame_cnt_q != 16'd0) || accept))) begin
          state_d = StDump;
        end
      end
      StDump: begin
        if (out_ready) begin
          bins_d[idx_q] = '0;
          idx_d         = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            state_d     = StAccum;
            frame_cnt_d = '0;
            sat_d       = 1'b0;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAccum;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      sat_q       <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      for (int i = 0; i < 32; i++) begin
        bins_q[i] <= bins_d[i];
      end
    end
  end

  // Outputs decode only from registered state.
  always_comb begin
    sym_ready = (state_q == StAccum);
    out_valid = (state_q == StDump);
    out_index = idx_q;
    out_count = out_valid ? bins_q[idx_q] : '0;
    out_last  = out_valid && (idx_q == 5'd31);
    out_sat   = out_valid && sat_q;
  end

endmodule

// File: tb/tb_tespar_histogram.sv
// Directed bench for tespar_histogram: default instance for frame/flush/
// backpressure/reset scenarios, and a FRAME_LEN=300 instance for saturation.
module tb_tespar_histogram;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sym_in;
  logic       sym_valid, flush, out_ready;
  logic       sym_ready, out_valid, out_last, out_sat;
  logic [4:0] out_index;
  logic [7:0] out_count;

  logic [4:0] s_sym_in;
  logic       s_sym_valid, s_flush, s_out_ready;
  logic       s_sym_ready, s_out_valid, s_out_last, s_out_sat;
  logic [4:0] s_out_index;
  logic [7:0] s_out_count;

  int errors = 0;
  int checks = 0;
  int exp_bins [32];

  always #5 clk = ~clk;

  tespar_histogram #(.FRAME_LEN(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .flush(flush), .out_index(out_index), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_sat(out_sat)
  );

  tespar_histogram #(.FRAME_LEN(300), .CNT_W(8)) dut_sat (
    .clk(clk), .reset(reset), .sym_in(s_sym_in), .sym_valid(s_sym_valid),
    .sym_ready(s_sym_ready), .flush(s_flush), .out_index(s_out_index),
    .out_count(s_out_count), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .out_sat(s_out_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: offer n copies of one symbol back-to-back, then idle.
  task automatic feed(input logic [4:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      sym_in    = s;
      sym_valid = 1'b1;
      tick();
    end
    sym_valid = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_bins[i] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sym_in = '0;
    s_sym_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0; s_sym_in = '0;
    tick();
    checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_sym_ready got=%b want=1", sym_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    checks++; if (out_index !== 5'd0) begin errors++; $display("FAIL reset_out_index got=%0d want=0", out_index); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count got=%0d want=0", out_count); end
    reset = 1'b0;
    tick();
    checks++; if (sym_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_after got ready=%b valid=%b want 1/0", sym_ready, out_valid);
    end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    feed(5'd3, 8);
    feed(5'd7, 5);
    feed(5'd31, 2);
    checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin
      errors++; $display("FAIL frame_early_dump got valid=%b ready=%b want 0/1", out_valid, sym_ready);
    end
    feed(5'd31, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_dump_start got=%b want=1", out_valid); end
    clear_exp(); exp_bins[3] = 8; exp_bins[7] = 5; exp_bins[31] = 3;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 5'(i) || out_count !== 8'(exp_bins[i]) ||
          out_last !== (i == 31) || out_sat !== 1'b0 || sym_ready !== 1'b0) begin
        errors++;
        $display("FAIL frame_bin%0d got v=%b idx=%0d cnt=%0d last=%b sat=%b rdy=%b want cnt=%0d",
                 i, out_valid, out_index, out_count, out_last, out_sat, sym_ready, exp_bins[i]);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin
      errors++; $display("FAIL frame_return got valid=%b ready=%b want 0/1", out_valid, sym_ready);
    end
  endtask

  // Starts on the very cycle after out_last; bin3/7/31 residue would show.
  task automatic test_back_to_back();
    feed(5'd7, 16);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_dump_start got=%b want=1", out_valid); end
    clear_exp(); exp_bins[7] = 16;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_index !== 5'(i) || out_count !== 8'(exp_bins[i]) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bin%0d got idx=%0d cnt=%0d v=%b want cnt=%0d",
                 i, out_index, out_count, out_valid, exp_bins[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty got valid=%b ready=%b want 0/1", out_valid, sym_ready);
    end
    feed(5'd9, 4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early got=%b want=0", out_valid); end
    sym_in = 5'd9; sym_valid = 1'b1; flush = 1'b1;
    tick();
    sym_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_dump_start got=%b want=1", out_valid); end
    clear_exp(); exp_bins[9] = 5;
    // flush stays high through the dump and must have no effect.
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_index !== 5'(i) || out_count !== 8'(exp_bins[i]) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL flush_bin%0d got idx=%0d cnt=%0d v=%b want cnt=%0d",
                 i, out_index, out_count, out_valid, exp_bins[i]);
      end
      tick();
    end
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_return got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    out_ready = 1'b1;
    feed(5'd20, 10);
    feed(5'd21, 6);
    clear_exp(); exp_bins[20] = 10; exp_bins[21] = 6;
    idx = 0;
    cyc = 0;
    sym_in = 5'd4; sym_valid = 1'b1;
    while (idx < 32 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 5'(idx) || out_count !== 8'(exp_bins[idx]) ||
          out_last !== (idx == 31) || out_sat !== 1'b0 || sym_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_cyc%0d got v=%b idx=%0d cnt=%0d last=%b rdy=%b want idx=%0d cnt=%0d",
                 cyc, out_valid, out_index, out_count, out_last, sym_ready, idx, exp_bins[idx]);
      end
      tick();
      if (out_ready) idx++;
      cyc++;
    end
    sym_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (idx != 32) begin errors++; $display("FAIL bp_timeout got idx=%0d want=32", idx); end
    // Symbols offered during the dump must not have entered the next frame.
    feed(5'd12, 15);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got=%b want=0", out_valid); end
    feed(5'd12, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_frame got=%b want=1", out_valid); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_count !== ((i == 12) ? 8'd16 : 8'd0)) begin
        errors++; $display("FAIL bp_next_bin%0d got=%0d", i, out_count);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump();
    out_ready = 1'b1;
    feed(5'd20, 16);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (out_index !== 5'd10) begin errors++; $display("FAIL rst_mid_idx got=%0d want=10", out_index); end
    reset = 1'b1; sym_in = 5'd1; sym_valid = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; sym_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sym_ready !== 1'b1 || out_index !== 5'd0 || out_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_state got v=%b rdy=%b idx=%0d cnt=%0d want 0/1/0/0",
               out_valid, sym_ready, out_index, out_count);
    end
    feed(5'd0, 16);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_dump got=%b want=1", out_valid); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_index !== 5'(i) || out_count !== ((i == 0) ? 8'd16 : 8'd0)) begin
        errors++; $display("FAIL rst_mid_bin%0d got idx=%0d cnt=%0d", i, out_index, out_count);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b1;
    for (int i = 0; i < 299; i++) begin
      s_sym_in = 5'd5; s_sym_valid = 1'b1;
      tick();
    end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_early got=%b want=0", s_out_valid); end
    tick();
    s_sym_valid = 1'b0;
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sat_dump_start got=%b want=1", s_out_valid); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (s_out_index !== 5'(i) || s_out_count !== ((i == 5) ? 8'd255 : 8'd0) ||
          s_out_sat !== 1'b1 || s_out_last !== (i == 31)) begin
        errors++;
        $display("FAIL sat_bin%0d got idx=%0d cnt=%0d sat=%b last=%b",
                 i, s_out_index, s_out_count, s_out_sat, s_out_last);
      end
      tick();
    end
    checks++; if (s_out_valid !== 1'b0 || s_out_sat !== 1'b0) begin
      errors++; $display("FAIL sat_return got valid=%b sat=%b want 0/0", s_out_valid, s_out_sat);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_reset_mid_dump();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tespar_histogram.md
TESPAR_HISTOGRAM -- requirements
Module: tespar_histogram

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning symbols accepted per frame (range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 8, meaning bin counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sym_in  input  5  TESPAR alphabet symbol from the alphabet generator (values 0..31).
REQ-006 SHALL have port sym_valid  input  1  sym_in is valid this cycle.
REQ-007 SHALL have port sym_ready  output  1  block can accept a symbol this cycle.
REQ-008 SHALL have port flush  input  1  end the current frame early.
REQ-009 SHALL have port out_index  output  5  bin number being presented.
REQ-010 SHALL have port out_count  output  CNT_W  count for bin out_index.
REQ-011 SHALL have port out_valid  output  1  out_index/out_count are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the presented bin.
REQ-013 SHALL have port out_last  output  1  presented bin is bin 31.
REQ-014 SHALL have port out_sat  output  1  at least one bin saturated in this frame; valid while out_valid.

Function
REQ-015 SHALL hold 32 bins of CNT_W bits, a frame counter of 16 bits, a 5-bit dump index and a sticky saturation flag.
REQ-016 SHALL implement states ACCUM and DUMP only.
REQ-017 ACCUM: sym_ready=1, out_valid=0.
REQ-018 A symbol is accepted when sym_valid=1 and sym_ready=1. On acceptance, bin[sym_in] increments by 1 and the frame counter increments by 1.
REQ-019 The increment of a bin already at 2^CNT_W-1 SHALL leave that bin unchanged and set the saturation flag. The accepted symbol still counts toward the frame.
REQ-020 ACCUM->DUMP SHALL occur on the cycle after the acceptance that brings the frame counter to FRAME_LEN.
REQ-021 ACCUM->DUMP SHALL occur on the cycle after flush=1 while the frame counter is nonzero or a symbol is accepted in the same cycle. A symbol accepted in that cycle is counted first.
REQ-022 flush=1 with the frame counter at 0 and no symbol accepted SHALL be ignored.
REQ-023 DUMP: sym_ready=0, out_valid=1. Symbols offered during DUMP are not consumed; upstream holds them.
REQ-024 DUMP SHALL present bins in index order 0..31. out_index equals the dump index, and out_count equals that bin's value. out_last=1 only when out_index=31.
REQ-025 On out_valid and out_ready, the presented bin SHALL clear to 0 and the dump index SHALL increment.
REQ-026 While out_ready=0, out_index/out_count/out_last/out_sat SHALL hold stable.
REQ-027 After the handshake with out_last=1, the block SHALL return to ACCUM on the next cycle. The frame counter, dump index and saturation flag clear, and all bins are 0.
REQ-028 Dump latency SHALL be 32 cycles minimum, at one bin per cycle with out_ready held high.
REQ-029 flush during DUMP SHALL be ignored.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-031 reset=1 at a clock edge SHALL force ACCUM and clear all bins, the frame counter, the dump index and the saturation flag, regardless of the current state, including mid-dump.
REQ-032 Output values during reset and the cycle after: sym_ready=1, out_valid=0, out_last=0, out_sat=0, out_index=0, out_count=0.
REQ-033 reset SHALL take priority over symbol acceptance, flush and output handshakes in the same cycle.

Verification
REQ-034 Full frame: feed 16 symbols {3 x8, 7 x5, 31 x3} back-to-back with out_ready=1 -> DUMP starts on the cycle after the 16th acceptance. The dump shows bin3=8, bin7=5, bin31=3 and all other bins 0. out_last=1 only at index 31, and out_sat=0.
REQ-035 Saturation: FRAME_LEN=300, CNT_W=8, feed symbol 5 x300 -> bin5=255, out_sat=1, and DUMP starts after the 300th symbol.
REQ-036 Flush: accept 4 symbols of value 9, assert flush together with a 5th symbol of value 9 -> dump shows bin9=5. Also check that flush with the frame counter at 0 causes no dump.
REQ-037 Backpressure: during DUMP, drive out_ready as the pattern 1,0,0,1,... -> outputs stay stable while out_ready=0, and no index is skipped or repeated. Symbols offered during DUMP are not consumed (sym_ready=0).
REQ-038 Reset mid-dump: assert reset at out_index=10 -> the next cycle shows ACCUM, out_valid=0, sym_ready=1. A following frame of 16 symbols of value 0 dumps as bin0=16 and all other bins 0.
REQ-039 Back-to-back frames: a second frame starts immediately after out_last -> its counts do not include any residue from the first frame.
